// File: rtl/readout_sequencer.sv
// readout_sequencer: gate-timing and readout master for the summator array.
//   The gate timer issues a periodic one-cycle readout_clr strobe. Two cycles
//   after each strobe, all channel sums and the frame number are snapshotted.
//   The frame (header, channel words) is then streamed over valid/ready.
//   A strobe that arrives while a frame is still latching or streaming is
//   dropped and counted in overrun_cnt, which saturates.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   enable       run gate timer (low holds it at reload, no strobe)
//   readout_clr  one-cycle clear strobe to all summators
//   sum_in       NCH x 16-bit channel sums, channel k at [16k+15:16k]
//   out_data/out_valid/out_ready/out_last  frame stream
//   overrun_cnt  saturating count of dropped frames
// Build option: define READOUT_CHECKSUM_EN to append an XOR checksum word
//   (header ^ all channel words) carrying out_last.
module readout_sequencer #(
  parameter int unsigned NCH           = 4,
  parameter int unsigned GATE_CYCLES   = 50000,
  parameter logic [15:0] FRAME_CNT_RST = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  output logic                readout_clr,
  input  logic [16*NCH-1:0]   sum_in,
  output logic [15:0]         out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic [7:0]          overrun_cnt
);

  localparam int unsigned GW = 24;
`ifdef READOUT_CHECKSUM_EN
  localparam int unsigned NWORDS = NCH + 2;
`else
  localparam int unsigned NWORDS = NCH + 1;
`endif
  localparam int unsigned IW = $clog2(NWORDS);
  localparam logic [GW-1:0] GATE_RELOAD = GW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LATCH, TX} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       gate_q, gate_d;
  logic                clr_q, clr_d;
  logic [15:0]         frame_q, frame_d;
  logic [7:0]          ovr_q, ovr_d;
  logic                wait_q, wait_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [15:0]         data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic [NCH-1:0][15:0] snap_q, snap_d;
  logic [IW-1:0]       nxt_idx;
  logic [15:0]         nxt_word;
`ifdef READOUT_CHECKSUM_EN
  logic [15:0]         csum_q, csum_d;
  logic [15:0]         csum_in;
`endif

  assign nxt_idx = idx_q + IW'(1);

  // Word following the current one; index 0 (header) is loaded at capture.
  always_comb begin
    nxt_word = 16'h0000;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (nxt_idx == IW'(k + 1)) nxt_word = snap_q[k];
    end
`ifdef READOUT_CHECKSUM_EN
    if (nxt_idx == IW'(NCH + 1)) nxt_word = csum_q;
`endif
  end

`ifdef READOUT_CHECKSUM_EN
  // Checksum of the frame being captured this cycle.
  always_comb begin
    csum_in = frame_q;
    for (int unsigned k = 0; k < NCH; k++) csum_in = csum_in ^ sum_in[16*k +: 16];
  end
`endif

  // Next-state: gate timer, overrun counter and frame FSM.
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    clr_d   = 1'b0;
    frame_d = frame_q;
    ovr_d   = ovr_q;
    wait_d  = wait_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    snap_d  = snap_q;
`ifdef READOUT_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    if (!enable) begin
      gate_d = GATE_RELOAD;
    end else if (gate_q == '0) begin
      gate_d  = GATE_RELOAD;
      clr_d   = 1'b1;
      frame_d = frame_q + 16'd1;
    end else begin
      gate_d = gate_q - GW'(1);
    end

    // Strobe while busy: frame is dropped but still numbered.
    if (clr_q && (state_q != IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (clr_q) begin
          state_d = LATCH;
          wait_d  = 1'b0;
        end
      end
      // Summators update one cycle after the strobe; sample on the second.
      LATCH: begin
        wait_d = 1'b1;
        if (wait_q) begin
          snap_d  = sum_in;
          data_d  = frame_q;
          valid_d = 1'b1;
          last_d  = 1'b0;
          idx_d   = '0;
          state_d = TX;
`ifdef READOUT_CHECKSUM_EN
          csum_d  = csum_in;
`endif
        end
      end
      TX: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d  = nxt_idx;
            data_d = nxt_word;
            last_d = (nxt_idx == IW'(NWORDS - 1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gate_q  <= GATE_RELOAD;
      clr_q   <= 1'b0;
      frame_q <= FRAME_CNT_RST;
      ovr_q   <= 8'h00;
      wait_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= 16'h0000;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      snap_q  <= '0;
`ifdef READOUT_CHECKSUM_EN
      csum_q  <= 16'h0000;
`endif
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      clr_q   <= clr_d;
      frame_q <= frame_d;
      ovr_q   <= ovr_d;
      wait_q  <= wait_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      snap_q  <= snap_d;
`ifdef READOUT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign readout_clr = clr_q;
  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_last    = last_q;
  assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_readout_sequencer.sv
// tb_readout_sequencer: randomized bench for readout_sequencer with a
// frame-level reference model (strobe = run of enabled cycles reaching a
// multiple of the gate period; frames held as a queue of expected words).
// A second instance starts its frame counter near 0xFFFF to show the wrap.
module tb_readout_sequencer;

  localparam int NCH = 4;
  localparam int G   = 20;
`ifdef READOUT_CHECKSUM_EN
  localparam bit CSUM   = 1'b1;
  localparam int NWORDS = NCH + 2;
`else
  localparam bit CSUM   = 1'b0;
  localparam int NWORDS = NCH + 1;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                enable = 1'b0;
  logic                out_ready = 1'b0;
  logic [16*NCH-1:0]   sum_in = '0;
  logic                readout_clr;
  logic [15:0]         out_data;
  logic                out_valid;
  logic                out_last;
  logic [7:0]          overrun_cnt;

  logic                w_clr;
  logic [15:0]         w_data;
  logic                w_valid;
  logic                w_last;
  logic [7:0]          w_ovr;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          run = 0;
  bit          m_clr = 1'b0;
  logic [15:0] m_fc = 16'h0000;
  int          m_ov = 0;
  int          cap_in = -1;
  logic [15:0] words[$];

  // Wrap-instance monitor state
  logic [15:0] w_hdrs[$];
  logic        w_prev = 1'b0;
  int          w_nclr = 0;
  int          w_nlast = 0;

  always #5 clk = ~clk;

  readout_sequencer #(.NCH(NCH), .GATE_CYCLES(G)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .readout_clr(readout_clr),
    .sum_in(sum_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .overrun_cnt(overrun_cnt)
  );

  readout_sequencer #(.NCH(NCH), .GATE_CYCLES(G), .FRAME_CNT_RST(16'hFFFE)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .readout_clr(w_clr),
    .sum_in(sum_in), .out_data(w_data), .out_valid(w_valid),
    .out_ready(1'b1), .out_last(w_last), .overrun_cnt(w_ovr)
  );

  always @(negedge clk) begin
    if (w_valid && !w_prev) w_hdrs.push_back(w_data);
    if (w_clr) w_nclr++;
    if (w_valid && w_last) w_nlast++;
    w_prev = w_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [16*NCH-1:0] rand_sums();
    logic [16*NCH-1:0] v;
    for (int k = 0; k < NCH; k++) v[16*k +: 16] = 16'($urandom);
    return v;
  endfunction

  // Advance the model across the coming clock edge using current inputs.
  task automatic model_edge();
    bit          accept;
    logic [15:0] cs;
    accept = 1'b0;
    if (!rst_n) begin
      run = 0; m_clr = 1'b0; m_fc = 16'h0000; m_ov = 0; cap_in = -1;
      words.delete();
      return;
    end
    if (m_clr) begin
      m_fc = m_fc + 16'd1;
      if (cap_in >= 0 || words.size() != 0) begin
        if (m_ov < 255) m_ov++;
      end else begin
        accept = 1'b1;
      end
    end
    if (words.size() != 0 && out_ready) words.delete(0);
    if (cap_in == 1) begin
      cs = m_fc;
      words.push_back(m_fc);
      for (int k = 0; k < NCH; k++) begin
        words.push_back(sum_in[16*k +: 16]);
        cs = cs ^ sum_in[16*k +: 16];
      end
      if (CSUM) words.push_back(cs);
      cap_in = -1;
    end else if (cap_in > 1) begin
      cap_in--;
    end
    if (accept) cap_in = 2;
    if (enable) begin
      run++;
      m_clr = (run % G == 0);
    end else begin
      run = 0;
      m_clr = 1'b0;
    end
  endtask

  // One clock cycle: model, edge, compare, new random sums.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("readout_clr", 32'(readout_clr), 32'(m_clr));
    check("out_valid", 32'(out_valid), 32'(words.size() != 0));
    if (words.size() != 0) begin
      check("out_data", 32'(out_data), 32'(words[0]));
      check("out_last", 32'(out_last), 32'(words.size() == 1));
    end
    check("overrun_cnt", 32'(overrun_cnt), 32'(m_ov));
    sum_in = rand_sums();
  endtask

  initial begin
    int guard;
    sum_in = rand_sums();

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_data", 32'(out_data), 32'h0);
    check("rst_last", 32'(out_last), 32'h0);

    // First frames, sink always ready
    rst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    repeat (60) tick();
    check("wrap_nhdr", 32'(w_hdrs.size() >= 2), 32'h1);
    if (w_hdrs.size() >= 2) begin
      check("wrap_hdr0", 32'(w_hdrs[0]), 32'hFFFF);
      check("wrap_hdr1", 32'(w_hdrs[1]), 32'h0000);
    end
    check("wrap_nclr", 32'(w_nclr), 32'd2);
    check("wrap_nlast", 32'(w_nlast), 32'd2);
    check("wrap_ovr", 32'(w_ovr), 32'h0);

    // Stall on header for several cycles
    guard = 0;
    while (cap_in != 1 && guard < 100) begin tick(); guard++; end
    check("wait_capture", 32'(cap_in == 1), 32'h1);
    out_ready = 1'b0;
    repeat (6) tick();
    out_ready = 1'b1;
    repeat (20) tick();

    // Random back-pressure
    repeat (200) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Long stall spanning three gate periods
    out_ready = 1'b0;
    repeat (65) tick();
    out_ready = 1'b1;
    repeat (60) tick();

    // Random enable drops with random back-pressure
    repeat (400) begin
      enable    = ($urandom_range(0, 99) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end

    // Reset right after a header transfer
    enable = 1'b1; out_ready = 1'b1;
    guard = 0;
    while (words.size() != NWORDS - 1 && guard < 200) begin tick(); guard++; end
    check("wait_hdr_xfer", 32'(words.size() == NWORDS - 1), 32'h1);
    rst_n = 1'b0;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_data", 32'(out_data), 32'h0);
    check("mid_rst_last", 32'(out_last), 32'h0);
    rst_n = 1'b1;
    repeat (60) tick();

    // Saturate the overrun counter
    out_ready = 1'b0;
    repeat (G * 305) tick();
    check("ovr_saturated", 32'(overrun_cnt), 32'hFF);
    out_ready = 1'b1;
    repeat (40) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
